// File: rtl/mips_mem_arbiter_pkg.sv
// Shared defaults and the read-owner encoding for the MIPS memory arbiter.
package mips_mem_pkg;

    localparam int DEF_AW         = 10;
    localparam int DEF_DW         = 32;
    localparam int DEF_MAX_STREAK = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Width able to hold every value 0..max inclusive.
    function automatic int streak_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Fetch, data and memory-side signals shared between the arbiter and its environment.
interface mips_mem_arbiter_if #(
    parameter int AW = mips_mem_pkg::DEF_AW,
    parameter int DW = mips_mem_pkg::DEF_DW
);
    logic          halted;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  halted,
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Pipeline and memory side
    modport master (
        output halted,
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data stage; data
// has priority, but fetch is forced through after MAX_STREAK consecutive data wins.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int MAX_STREAK = DEF_MAX_STREAK
) (
    input  logic                clk1,
    input  logic                rst,
    mips_mem_arbiter_if.slave   bus
);

    localparam int             SW         = streak_width(MAX_STREAK);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_STREAK);

    logic          eff_if;
    logic          if_gnt;
    logic          d_gnt;
    logic          if_rvalid;
    logic          d_rvalid;

    logic [SW-1:0] streak_reg, streak_next;
    logic          rd_valid_reg, rd_valid_next;
    owner_t        owner_reg, owner_next;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] d_rdata_reg;

    assign eff_if = bus.if_req && !bus.halted;

    // Grants are gated by rst so nothing reaches memory during reset.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (!rst) begin
            if (bus.d_req && !(eff_if && (streak_reg == STREAK_MAX))) begin
                d_gnt = 1'b1;
            end else if (eff_if) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Streak only measures how long a live fetch has been starved.
    always_comb begin
        streak_next = streak_reg;
        if (!eff_if || if_gnt) begin
            streak_next = '0;
        end else if (d_gnt && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_comb begin
        rd_valid_next = if_gnt || (d_gnt && !bus.d_we);
        owner_next    = d_gnt ? OWN_D : OWN_IF;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            streak_reg   <= '0;
            rd_valid_reg <= 1'b0;
            owner_reg    <= OWN_IF;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            streak_reg   <= streak_next;
            rd_valid_reg <= rd_valid_next;
            owner_reg    <= owner_next;
            if (if_rvalid) begin
                if_rdata_reg <= bus.mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_reg <= bus.mem_rdata;
            end
        end
    end

    // A read in flight when reset arrives is dropped rather than returned.
    assign if_rvalid = rd_valid_reg && (owner_reg == OWN_IF) && !rst;
    assign d_rvalid  = rd_valid_reg && (owner_reg == OWN_D)  && !rst;

    assign bus.if_gnt    = if_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_reg;
    assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : d_rdata_reg;

    assign bus.mem_en    = if_gnt || d_gnt;
    assign bus.mem_we    = d_gnt && bus.d_we;
    assign bus.mem_addr  = d_gnt ? bus.d_addr : bus.if_addr;
    assign bus.mem_wdata = bus.d_wdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a 1-cycle memory model and a read scoreboard.
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    localparam int AW    = DEF_AW;
    localparam int DW    = DEF_DW;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        owner_t        owner;
        logic [DW-1:0] data;
    } sb_t;

    logic clk1;
    logic rst;

    mips_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mips_mem_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(DEF_MAX_STREAK)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Memory model: reloads its contents during reset, read data one cycle after mem_en.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk1) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= 32'h2801000a + DW'(k);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    logic [DW-1:0] shadow [0:DEPTH-1];
    sb_t           sb [$];
    logic [DW-1:0] last_if;
    logic [DW-1:0] last_d;
    int            vectors;
    int            errors;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reload_shadow();
        for (int k = 0; k < DEPTH; k++) shadow[k] = 32'h2801000a + DW'(k);
    endtask

    task automatic drive(input logic ifr, input logic [AW-1:0] ia, input logic dr,
                         input logic we, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         input logic hlt);
        bus.if_req  = ifr;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.halted  = hlt;
    endtask

    // One cycle: check returns due from the previous cycle, then this cycle's grants.
    task automatic tick(input string tag, input logic e_ig, input logic e_dg);
        sb_t  ent;
        logic exp_iv;
        logic exp_dv;
        logic [DW-1:0] exp_data;
        logic [AW-1:0] exp_addr;
        @(negedge clk1);
        exp_iv   = 1'b0;
        exp_dv   = 1'b0;
        exp_data = '0;
        if (rst) begin
            sb.delete();
        end else if (sb.size() > 0) begin
            ent      = sb.pop_front();
            exp_data = ent.data;
            if (ent.owner == OWN_D) exp_dv = 1'b1;
            else                    exp_iv = 1'b1;
        end
        chk({tag, ".if_rvalid"}, DW'(bus.if_rvalid), DW'(exp_iv));
        chk({tag, ".d_rvalid"},  DW'(bus.d_rvalid),  DW'(exp_dv));
        if (!rst) begin
            chk({tag, ".if_rdata"}, bus.if_rdata, exp_iv ? exp_data : last_if);
            chk({tag, ".d_rdata"},  bus.d_rdata,  exp_dv ? exp_data : last_d);
            if (exp_iv) last_if = exp_data;
            if (exp_dv) last_d  = exp_data;
        end
        chk({tag, ".if_gnt"}, DW'(bus.if_gnt), DW'(e_ig));
        chk({tag, ".d_gnt"},  DW'(bus.d_gnt),  DW'(e_dg));
        chk({tag, ".mem_en"}, DW'(bus.mem_en), DW'(e_ig | e_dg));
        chk({tag, ".mem_we"}, DW'(bus.mem_we), DW'(e_dg & bus.d_we));
        if (e_ig || e_dg) begin
            exp_addr = e_dg ? bus.d_addr : bus.if_addr;
            chk({tag, ".mem_addr"}, DW'(bus.mem_addr), DW'(exp_addr));
            if (e_dg && bus.d_we) begin
                chk({tag, ".mem_wdata"}, bus.mem_wdata, bus.d_wdata);
                shadow[bus.d_addr] = bus.d_wdata;
            end else begin
                sb.push_back('{owner: (e_dg ? OWN_D : OWN_IF), data: shadow[exp_addr]});
            end
        end
        $display("%0t %s if_gnt=%0b d_gnt=%0b if_rvalid=%0b d_rvalid=%0b", $time, tag,
                 bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid);
        @(posedge clk1);
        #1;
        if (rst) begin
            last_if = '0;
            last_d  = '0;
            reload_shadow();
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        last_if = '0;
        last_d  = '0;
        reload_shadow();

        // Reset with both requests asserted: grants must stay low.
        rst = 1'b1;
        drive(1'b1, 10'd0, 1'b1, 1'b0, 10'd1, '0, 1'b0);
        tick("reset", 1'b0, 1'b0);
        tick("reset", 1'b0, 1'b0);

        rst = 1'b0;
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick("idle", 1'b0, 1'b0);

        // Back-to-back fetches of words 0..3.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(i), 1'b0, 1'b0, 10'd0, '0, 1'b0);
            tick("fetch", 1'b1, 1'b0);
        end
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        tick("fetch_drain", 1'b0, 1'b0);

        // Data write then read-back of address 7.
        drive(1'b0, 10'd0, 1'b1, 1'b1, 10'd7, 32'h00000019, 1'b0);
        tick("d_write", 1'b0, 1'b1);
        drive(1'b0, 10'd0, 1'b1, 1'b0, 10'd7, 32'hdeadbeef, 1'b0);
        tick("d_read", 1'b0, 1'b1);
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        tick("d_drain", 1'b0, 1'b0);

        // Contention: D x4, IF, then the streak restarts from zero.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 10'd10, 1'b1, 1'b0, AW'(20 + i), '0, 1'b0);
            tick("contend", (i == 4 || i == 9), !(i == 4 || i == 9));
        end

        // A cycle with fetch idle clears the streak mid-run.
        drive(1'b1, 10'd11, 1'b1, 1'b0, 10'd40, '0, 1'b0);
        tick("streak_a", 1'b0, 1'b1);
        tick("streak_a", 1'b0, 1'b1);
        drive(1'b0, 10'd11, 1'b1, 1'b0, 10'd41, '0, 1'b0);
        tick("streak_clr", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'd12, 1'b1, 1'b0, AW'(42 + i), '0, 1'b0);
            tick("streak_b", (i == 4), (i != 4));
        end

        // Halt rising right after a fetch grant still returns that fetch.
        drive(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        tick("pre_halt", 1'b1, 1'b0);
        drive(1'b1, 10'd6, 1'b0, 1'b0, 10'd0, '0, 1'b1);
        for (int i = 0; i < 3; i++) tick("halted", 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10'd6, 1'b1, 1'b0, AW'(50 + i), '0, 1'b1);
            tick("halted_d", 1'b0, 1'b1);
        end
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        tick("halt_drain", 1'b0, 1'b0);

        // Reset arriving one cycle after a data read grant.
        drive(1'b0, 10'd0, 1'b1, 1'b0, 10'd60, '0, 1'b0);
        tick("rst_read", 1'b0, 1'b1);
        rst = 1'b1;
        tick("rst_mid", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'd3, 1'b1, 1'b0, AW'(7 + i), '0, 1'b0);
            tick("post_rst", (i == 4), (i != 4));
        end
        drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, '0, 1'b0);
        tick("final_drain", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
